// File: rtl/mux16_to_1_pkg.sv
// Shared constants for the registered 16:1 bit mux. MUX16_TO_1_PIPE_EN selects
// the two-cycle build; LAT lets users align expectations with either build.
package mux16_to_1_pkg;

   localparam int DATA_N     = 16;
   localparam int SEL_W      = 4;
   localparam int GROUP_N    = 4;
   localparam int GROUP_SIZE = DATA_N / GROUP_N;

`ifdef MUX16_TO_1_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

endpackage

// File: rtl/mux16_to_1_mux4to1.sv
// Combinational 4:1 mux leaf; d uses an ascending range so y = d[s] picks
// the leftmost bit for s = 0.
module mux4to1 (
   input  logic [0:3] d,
   input  logic [1:0] s,
   output logic       y
);

   assign y = d[s];

endmodule

// File: rtl/mux16_to_1.sv
// Registered 16:1 bit mux, Y = W[S] with W[0] the MSB, built as two tiers of
// 4:1 muxes. Defining MUX16_TO_1_PIPE_EN registers the tier-1 results (latency 2).
module mux16_to_1
   import mux16_to_1_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [0:DATA_N-1] W,
   input  logic [SEL_W-1:0]  S,
   output logic              Y
);

   logic [0:GROUP_N-1] w_tier1;
   logic [0:GROUP_N-1] w_tier2_d;
   logic [1:0]         w_tier2_s;
   logic               w_y;
   logic               r_y;

   genvar gi;
   generate
      for (gi = 0; gi < GROUP_N; gi++) begin : g_tier1
         mux4to1 u_mux (
            .d (W[GROUP_SIZE*gi +: GROUP_SIZE]),
            .s (S[1:0]),
            .y (w_tier1[gi])
         );
      end
   endgenerate

`ifdef MUX16_TO_1_PIPE_EN
   logic [0:GROUP_N-1] r_tier1;
   logic [1:0]         r_sel_hi;

   // Upper select bits travel with the tier-1 results so tier 2 stays aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tier1  <= '0;
         r_sel_hi <= '0;
      end else begin
         r_tier1  <= w_tier1;
         r_sel_hi <= S[3:2];
      end
   end

   assign w_tier2_d = r_tier1;
   assign w_tier2_s = r_sel_hi;
`else
   assign w_tier2_d = w_tier1;
   assign w_tier2_s = S[3:2];
`endif

   mux4to1 u_tier2 (
      .d (w_tier2_d),
      .s (w_tier2_s),
      .y (w_y)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y <= 1'b0;
      end else begin
         r_y <= w_y;
      end
   end

   assign Y = r_y;

endmodule

// File: tb/tb_mux16_to_1.sv
// Scoreboard bench for mux16_to_1: stimulus pushes model bits, a monitor pops
// them LAT edges later and also checks Y = 0 across every reset.
module tb_mux16_to_1;
   import mux16_to_1_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [0:15] W = '0;
   logic [3:0]  S = '0;
   logic        Y;

   bit          exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          ecnt    = 0;

   mux16_to_1 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .W     (W),
      .S     (S),
      .Y     (Y)
   );

   always #5 clk = ~clk;

   // Reference: bit (15 - s) of the integer value of w.
   function automatic bit model(input logic [15:0] w, input logic [3:0] s);
      int v;
      v = int'(w);
      return bit'((v >> (15 - int'(s))) & 1);
   endfunction

   // Apply one W/S pair for the coming edge; record its expected result.
   task automatic step(input logic [15:0] w, input logic [3:0] s);
      W = w;
      S = s;
      if (rst_n) exp_q.push_back(model(w, s));
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   // Monitor: owns the queue drain and the edge count since reset release.
   initial begin
      bit e;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            exp_q.delete();
            ecnt = 0;
            #1;
            n_tests++;
            if (Y !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_y: Y=%b expected 0 at t=%0t", Y, $time);
            end else
               $display("[TB] reset check Y=0 t=%0t", $time);
         end else begin
            ecnt++;
            @(negedge clk);
            if (ecnt < LAT) begin
               n_tests++;
               if (Y !== 1'b0) begin
                  n_fail++;
                  $display("FAIL post_reset_fill: Y=%b expected 0 edge=%0d", Y, ecnt);
               end
            end else if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_tests++;
               if (Y !== e) begin
                  n_fail++;
                  $display("FAIL data: Y=%b expected %b W=%h S=%0d t=%0t", Y, e, W, S, $time);
               end else
                  $display("[TB] ok Y=%b t=%0t", Y, $time);
            end
         end
      end
   end

   initial begin
      // Hold reset with all-ones data: Y must stay 0.
      W = 16'hFFFF;
      S = 4'd0;
      #1 rst_n = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      step(16'hFFFF, 4'd0);
      step(16'hFFFF, 4'd0);

      // Alternating sweep.
      for (int s = 0; s < 16; s++) step(16'hAAAA, 4'(s));

      // Walking one-hot against every select.
      for (int k = 0; k < 16; k++)
         for (int s = 0; s < 16; s++) step(16'h8000 >> k, 4'(s));

      // Constants.
      for (int s = 0; s < 16; s++) step(16'h0000, 4'(s));
      for (int s = 0; s < 16; s++) step(16'hFFFF, 4'(s));

      // Sweep interrupted by a partial-cycle reset; in-flight data is discarded.
      for (int s = 0; s < 7; s++) step(16'hAAAA, 4'(s));
      pulse_reset();
      for (int s = 7; s < 16; s++) step(16'hAAAA, 4'(s));

      // Random back-to-back traffic.
      for (int i = 0; i < 1000; i++)
         step(16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));

      // Drain the pipeline.
      for (int i = 0; i < LAT + 1; i++) step(16'h0000, 4'd0);
      @(posedge clk);
      #2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
